// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO access arbiter and its helpers.
package pio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/pio_access_arbiter_if.sv
// Bundles the requester handshake and the Avalon-MM PIO slave bus.
// The arbiter uses the master view; requesters plus the PIO slave use the slave view.
interface pio_access_arbiter_if import pio_arb_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         rdata;

   logic [ADDR_W-1:0]         avs_address;
   logic                      avs_chipselect;
   logic                      avs_write_n;
   logic [DATA_W-1:0]         avs_writedata;
   logic [DATA_W-1:0]         avs_readdata;

   modport master (
      input  req, req_write, req_addr, req_wdata, avs_readdata,
      output gnt, ack, rdata, avs_address, avs_chipselect, avs_write_n, avs_writedata
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, avs_readdata,
      input  gnt, ack, rdata, avs_address, avs_chipselect, avs_write_n, avs_writedata
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first active request at or
// after the priority pointer, wrapping around the requester count.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
)(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // Walk the requesters starting at the pointer and keep the first one found.
   always_comb begin
      int j;
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (!valid_o && req_i[j]) begin
            valid_o    = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/pio_access_arbiter.sv
// Shares one zero-wait-state Avalon-MM PIO slave between several local
// requesters. Each transaction takes IDLE -> ISSUE -> ACK, with the winner's
// command latched on entry to ISSUE so late changes cannot disturb it.
module pio_access_arbiter import pio_arb_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
)(
   input  logic                 clk,
   input  logic                 reset,
   pio_access_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    ptr_d;
   logic [IDX_W-1:0]    owner_q;
   logic                wr_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                cs_q;
   logic                wn_q;

   logic [NUM_REQ-1:0]  winGrant;
   logic [IDX_W-1:0]    winIdx;
   logic                winValid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .grant_o (winGrant),
      .idx_o   (winIdx),
      .valid_o (winValid)
   );

   // Next priority pointer: one past the owner just served, wrapping to zero.
   always_comb begin
      ptr_d = owner_q + IDX_W'(1);
      if (owner_q == IDX_W'(NUM_REQ - 1)) begin
         ptr_d = '0;
      end
   end

   // Transaction sequencer with all bus and handshake outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         wr_q    <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cs_q    <= 1'b0;
         wn_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= '0;
               gnt_q <= '0;
               if (winValid) begin
                  owner_q <= winIdx;
                  wr_q    <= bus.req_write[winIdx];
                  addr_q  <= bus.req_addr[int'(winIdx)*ADDR_W +: ADDR_W];
                  wdata_q <= bus.req_wdata[int'(winIdx)*DATA_W +: DATA_W];
                  gnt_q   <= winGrant;
                  cs_q    <= 1'b1;
                  wn_q    <= ~bus.req_write[winIdx];
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (!wr_q) begin
                  rdata_q <= bus.avs_readdata;
               end
               cs_q    <= 1'b0;
               wn_q    <= 1'b1;
               ack_q   <= gnt_q;
               state_q <= ACK;
            end
            ACK: begin
               ack_q   <= '0;
               gnt_q   <= '0;
               ptr_q   <= ptr_d;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= '0;
               gnt_q   <= '0;
               cs_q    <= 1'b0;
               wn_q    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.gnt            = gnt_q;
   assign bus.ack            = ack_q;
   assign bus.rdata          = rdata_q;
   assign bus.avs_address    = addr_q;
   assign bus.avs_chipselect = cs_q;
   assign bus.avs_write_n    = wn_q;
   assign bus.avs_writedata  = wdata_q;

endmodule
